// File: rtl/mem_access_ctrl_if.sv
// Memory-side bus of mem_access_ctrl: one request/acknowledge transaction per access.
// Handshake: the master raises mem_req with mem_we/mem_addr/mem_wdata/mem_be and holds all of
// them stable until the slave returns a single-cycle mem_ack (mem_rdata valid in that cycle);
// mem_req drops on the following edge. mem_ack while mem_req is low has no meaning.
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: one bus access per instruction, pipeline stalled meanwhile.
// Optional macro MEM_TIMEOUT_EN adds an ACCESS timeout that raises AccessFaultM for one cycle.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] AddressM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  Funct3M,
  output logic        StallM,
  output logic        MisalignedM,
  output logic [31:0] ReadDataW,
  mem_access_ctrl_if.master mem,
  output logic        AccessFaultM,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  logic        request;
  logic        size_illegal;
  logic        misaligned;
  logic        legal_req;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic        load_pending;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_value;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  always_comb begin
    request      = MemReadM | MemWriteM;
    size_illegal = (Funct3M == 3'b011) || (Funct3M == 3'b110) || (Funct3M == 3'b111);
    case (Funct3M[1:0])
      2'b01:   misaligned = AddressM[0];
      2'b10:   misaligned = |AddressM[1:0];
      default: misaligned = 1'b0;
    endcase
    MisalignedM = request & (size_illegal | misaligned);
    legal_req   = request & ~MisalignedM;
    StallM      = ((state == IDLE) && legal_req) || (state == ACCESS);
  end

  // Store lanes are replicated so the memory only needs the byte enables to pick the target.
  always_comb begin
    case (Funct3M[1:0])
      2'b00: begin
        be_next    = 4'b0001 << AddressM[1:0];
        wdata_next = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << {AddressM[1], 1'b0};
        wdata_next = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = WriteDataM;
      end
    endcase
  end

  always_comb begin
    ld_byte = mem.mem_rdata[8*ld_off +: 8];
    ld_half = ld_off[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (ld_funct3)
      3'b000:  load_value = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_value = {24'd0, ld_byte};
      3'b001:  load_value = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_value = {16'd0, ld_half};
      default: load_value = mem.mem_rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] timeout_cnt;
  logic            access_fault;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 32'd0;
      mem.mem_wdata <= 32'd0;
      mem.mem_be    <= 4'd0;
      ReadDataW     <= 32'd0;
      load_pending  <= 1'b0;
      ld_funct3     <= 3'd0;
      ld_off        <= 2'd0;
`ifdef MEM_TIMEOUT_EN
      timeout_cnt   <= '0;
      access_fault  <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      access_fault <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (legal_req) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= MemWriteM;
            mem.mem_addr  <= {AddressM[31:2], 2'b00};
            mem.mem_wdata <= wdata_next;
            mem.mem_be    <= be_next;
            load_pending  <= ~MemWriteM;
            ld_funct3     <= Funct3M;
            ld_off        <= AddressM[1:0];
`ifdef MEM_TIMEOUT_EN
            timeout_cnt   <= '0;
`endif
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            if (load_pending) ReadDataW <= load_value;
            state       <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            mem.mem_req  <= 1'b0;
            access_fault <= 1'b1;
            state        <= DONE;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
`endif
        end
        // DONE lets the stalled instruction retire; its still-present request is not re-issued.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  assign AccessFaultM = access_fault;
`else
  assign AccessFaultM = 1'b0;
`endif

  assign fsm_state = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized loads/stores
// checked against a byte-addressed memory model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [31:0] AddressM, WriteDataM;
  logic [2:0]  Funct3M;
  logic        StallM, MisalignedM, AccessFaultM;
  logic [31:0] ReadDataW;
  logic [1:0]  fsm_state;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .MemReadM     (MemReadM),
    .MemWriteM    (MemWriteM),
    .AddressM     (AddressM),
    .WriteDataM   (WriteDataM),
    .Funct3M      (Funct3M),
    .StallM       (StallM),
    .MisalignedM  (MisalignedM),
    .ReadDataW    (ReadDataW),
    .mem          (bus),
    .AccessFaultM (AccessFaultM),
    .fsm_state    (fsm_state)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] ST_IDLE = 2'd0;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_load = 32'd0;

  int          obs_stall;
  logic        obs_stable, obs_we, obs_done_stall, obs_done_req, obs_fault, obs_post_req;
  logic [1:0]  obs_post_state;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata, obs_rdw;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be = 4'd0;
    for (int k = 0; k < size_of(f3); k++) be[(a % 4) + k] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w = 32'd0;
    int n = size_of(f3);
    for (int lane = 0; lane < 4; lane++) w[8*lane +: 8] = d[8*(lane % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input int n, input logic uns);
    if (!uns && n == 1 && v >= 32'd128)   return v - 32'd256;
    if (!uns && n == 2 && v >= 32'd32768) return v - 32'd65536;
    return v;
  endfunction

  task automatic idle_inputs();
    MemReadM = 1'b0; MemWriteM = 1'b0; AddressM = 32'd0; WriteDataM = 32'd0; Funct3M = 3'd0;
  endtask

  // Drives one full access; the memory answers after `delay` ACCESS cycles (delay >= 1).
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [2:0] f3, input int delay,
                            input logic [31:0] rdata);
    MemReadM = rd; MemWriteM = wr; AddressM = addr; WriteDataM = wd; Funct3M = f3;
    obs_stall = 0; obs_stable = 1'b1;
    #1;
    if (StallM) obs_stall++;
    @(posedge clk); #1;
    obs_we = bus.mem_we; obs_addr = bus.mem_addr; obs_wdata = bus.mem_wdata; obs_be = bus.mem_be;
    for (int k = 1; k <= delay; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (StallM) obs_stall++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== obs_addr || bus.mem_wdata !== obs_wdata ||
          bus.mem_be !== obs_be || bus.mem_we !== obs_we) obs_stable = 1'b0;
      if (k == delay) begin bus.mem_ack = 1'b1; bus.mem_rdata = rdata; end
    end
    @(posedge clk); #1;
    bus.mem_ack = 1'b0; bus.mem_rdata = $urandom();
    obs_done_stall = StallM; obs_done_req = bus.mem_req; obs_rdw = ReadDataW; obs_fault = AccessFaultM;
    @(posedge clk); #1;
    obs_post_req = bus.mem_req; obs_post_state = fsm_state;
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b0; idle_inputs(); bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
    #12;
    checks++; if (bus.mem_req !== 1'b0)    begin errors++; $display("FAIL reset_req got=%b exp=0", bus.mem_req); end
    checks++; if (bus.mem_we !== 1'b0)     begin errors++; $display("FAIL reset_we got=%b exp=0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 32'd0)  begin errors++; $display("FAIL reset_addr got=%h exp=0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", bus.mem_wdata); end
    checks++; if (bus.mem_be !== 4'd0)     begin errors++; $display("FAIL reset_be got=%b exp=0", bus.mem_be); end
    checks++; if (ReadDataW !== 32'd0)     begin errors++; $display("FAIL reset_rdw got=%h exp=0", ReadDataW); end
    checks++; if (AccessFaultM !== 1'b0)   begin errors++; $display("FAIL reset_fault got=%b exp=0", AccessFaultM); end
    checks++; if (StallM !== 1'b0)         begin errors++; $display("FAIL reset_stall got=%b exp=0", StallM); end
    checks++; if (fsm_state !== ST_IDLE)   begin errors++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_word();
    run_access(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 3, 32'h0);
    checks++; if (obs_be !== 4'b1111)        begin errors++; $display("FAIL sw_be got=%b exp=1111", obs_be); end
    checks++; if (obs_addr !== 32'h100)      begin errors++; $display("FAIL sw_addr got=%h exp=100", obs_addr); end
    checks++; if (obs_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got=%h exp=deadbeef", obs_wdata); end
    checks++; if (obs_we !== 1'b1)           begin errors++; $display("FAIL sw_we got=%b exp=1", obs_we); end
    checks++; if (obs_stall != 4)            begin errors++; $display("FAIL sw_stall_cycles got=%0d exp=4", obs_stall); end
    checks++; if (obs_stable !== 1'b1)       begin errors++; $display("FAIL sw_stable got=%b exp=1", obs_stable); end
    checks++; if (obs_done_stall !== 1'b0)   begin errors++; $display("FAIL sw_done_stall got=%b exp=0", obs_done_stall); end
    checks++; if (obs_done_req !== 1'b0)     begin errors++; $display("FAIL sw_done_req got=%b exp=0", obs_done_req); end
    checks++; if (obs_rdw !== last_load)     begin errors++; $display("FAIL sw_rdw_hold got=%h exp=%h", obs_rdw, last_load); end
  endtask

  task automatic test_load_byte();
    run_access(1'b1, 1'b0, 32'h103, 32'h0, 3'b000, 1, 32'h80FF_FFFF);
    checks++; if (obs_rdw !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got=%h exp=ffffff80", obs_rdw); end
    checks++; if (obs_stall != 2)           begin errors++; $display("FAIL lb_min_latency got=%0d exp=2", obs_stall); end
    checks++; if (obs_we !== 1'b0)          begin errors++; $display("FAIL lb_we got=%b exp=0", obs_we); end
    checks++; if (obs_addr !== 32'h100)     begin errors++; $display("FAIL lb_addr got=%h exp=100", obs_addr); end
    run_access(1'b1, 1'b0, 32'h103, 32'h0, 3'b100, 2, 32'h80FF_FFFF);
    checks++; if (obs_rdw !== 32'h00000080) begin errors++; $display("FAIL lbu_data got=%h exp=00000080", obs_rdw); end
    last_load = 32'h00000080;
  endtask

  task automatic test_store_half();
    run_access(1'b0, 1'b1, 32'h202, 32'h0000_1234, 3'b001, 2, 32'h0);
    checks++; if (obs_be !== 4'b1100)         begin errors++; $display("FAIL sh_be got=%b exp=1100", obs_be); end
    checks++; if (obs_wdata !== 32'h12341234) begin errors++; $display("FAIL sh_wdata got=%h exp=12341234", obs_wdata); end
    checks++; if (obs_addr !== 32'h200)       begin errors++; $display("FAIL sh_addr got=%h exp=200", obs_addr); end
    // Read and write both asserted behaves as a store.
    run_access(1'b1, 1'b1, 32'h301, 32'h0000_00A5, 3'b000, 1, 32'h1122_3344);
    checks++; if (obs_we !== 1'b1)            begin errors++; $display("FAIL rw_we got=%b exp=1", obs_we); end
    checks++; if (obs_be !== 4'b0010)         begin errors++; $display("FAIL rw_be got=%b exp=0010", obs_be); end
    checks++; if (obs_rdw !== last_load)      begin errors++; $display("FAIL rw_rdw_hold got=%h exp=%h", obs_rdw, last_load); end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs[3] = '{32'h101, 32'h201, 32'h400};
    logic [2:0]  f3s[3]   = '{3'b010, 3'b001, 3'b011};
    for (int i = 0; i < 3; i++) begin
      MemReadM = 1'b1; MemWriteM = (i == 1); AddressM = addrs[i]; Funct3M = f3s[i];
      #1;
      checks++; if (MisalignedM !== 1'b1) begin errors++; $display("FAIL mis_flag[%0d] got=%b exp=1", i, MisalignedM); end
      checks++; if (StallM !== 1'b0)      begin errors++; $display("FAIL mis_stall[%0d] got=%b exp=0", i, StallM); end
      @(posedge clk); #1;
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL mis_req[%0d] got=%b exp=0", i, bus.mem_req); end
      idle_inputs();
    end
  endtask

  task automatic test_ack_outside();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    checks++; if (ReadDataW !== last_load) begin errors++; $display("FAIL stray_ack_rdw got=%h exp=%h", ReadDataW, last_load); end
    checks++; if (fsm_state !== ST_IDLE)   begin errors++; $display("FAIL stray_ack_state got=%0d exp=0", fsm_state); end
    checks++; if (bus.mem_req !== 1'b0)    begin errors++; $display("FAIL stray_ack_req got=%b exp=0", bus.mem_req); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, 32'h502, 32'h0, 3'b001, 1, 32'h8001_7FFF);
    checks++; if (obs_rdw !== 32'hFFFF8001)  begin errors++; $display("FAIL b2b_lh got=%h exp=ffff8001", obs_rdw); end
    checks++; if (obs_post_req !== 1'b0)     begin errors++; $display("FAIL b2b_done_ignored got=%b exp=0", obs_post_req); end
    checks++; if (obs_post_state !== ST_IDLE) begin errors++; $display("FAIL b2b_post_state got=%0d exp=0", obs_post_state); end
    run_access(1'b1, 1'b0, 32'h500, 32'h0, 3'b101, 1, 32'h8001_9ABC);
    checks++; if (obs_rdw !== 32'h00009ABC)  begin errors++; $display("FAIL b2b_lhu got=%h exp=00009abc", obs_rdw); end
    last_load = 32'h00009ABC;
  endtask

  task automatic test_random();
    logic [7:0]  mem_bytes[64];
    logic [31:0] base, addr, wd, word, v, exp_v;
    logic [2:0]  f3;
    logic        rd, wr, ok;
    int          op, off, n, delay, wb;
    logic [2:0]  ld_f3s[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  bad_f3s[3] = '{3'b011, 3'b110, 3'b111};
    for (int i = 0; i < 64; i++) mem_bytes[i] = 8'($urandom_range(0, 255));
    for (int it = 0; it < 48; it++) begin
      op = $urandom_range(0, 3);
      rd = (op != 2); wr = (op >= 2);
      f3 = wr ? ld_f3s[$urandom_range(0, 2)] : ld_f3s[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) f3 = bad_f3s[$urandom_range(0, 2)];
      off = $urandom_range(0, 63); base = $urandom(); wd = $urandom();
      addr = {base[31:6], 6'(off)};
      n = size_of(f3);
      ok = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) && (off % n == 0);
      if (!ok) begin
        MemReadM = rd; MemWriteM = wr; AddressM = addr; WriteDataM = wd; Funct3M = f3;
        #1;
        checks++; if (MisalignedM !== 1'b1) begin errors++; $display("FAIL rnd_mis_flag it=%0d got=%b exp=1", it, MisalignedM); end
        checks++; if (StallM !== 1'b0)      begin errors++; $display("FAIL rnd_mis_stall it=%0d got=%b exp=0", it, StallM); end
        @(posedge clk); #1;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rnd_mis_req it=%0d got=%b exp=0", it, bus.mem_req); end
        idle_inputs();
      end else begin
        wb = off - (off % 4);
        word = {mem_bytes[wb+3], mem_bytes[wb+2], mem_bytes[wb+1], mem_bytes[wb]};
        delay = $urandom_range(1, 4);
        run_access(rd, wr, addr, wd, f3, delay, word);
        checks++; if (obs_stall != delay + 1) begin errors++; $display("FAIL rnd_stall it=%0d got=%0d exp=%0d", it, obs_stall, delay + 1); end
        checks++; if (obs_stable !== 1'b1)    begin errors++; $display("FAIL rnd_stable it=%0d got=%b exp=1", it, obs_stable); end
        checks++; if (obs_done_stall !== 1'b0 || obs_post_req !== 1'b0)
          begin errors++; $display("FAIL rnd_done it=%0d got=%b%b exp=00", it, obs_done_stall, obs_post_req); end
        checks++; if (obs_addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL rnd_addr it=%0d got=%h exp=%h", it, obs_addr, {addr[31:2], 2'b00}); end
        checks++; if (obs_we !== wr)          begin errors++; $display("FAIL rnd_we it=%0d got=%b exp=%b", it, obs_we, wr); end
        if (wr) begin
          checks++; if (obs_be !== model_be(f3, addr)) begin errors++; $display("FAIL rnd_be it=%0d got=%b exp=%b", it, obs_be, model_be(f3, addr)); end
          checks++; if (obs_wdata !== model_wdata(f3, wd)) begin errors++; $display("FAIL rnd_wdata it=%0d got=%h exp=%h", it, obs_wdata, model_wdata(f3, wd)); end
          checks++; if (obs_rdw !== last_load) begin errors++; $display("FAIL rnd_st_rdw it=%0d got=%h exp=%h", it, obs_rdw, last_load); end
          for (int k = 0; k < n; k++) mem_bytes[off + k] = wd[8*k +: 8];
        end else begin
          v = 32'd0;
          for (int k = 0; k < n; k++) v = v | (32'(mem_bytes[off + k]) << (8 * k));
          exp_q.push_back(extend(v, n, f3[2]));
          exp_v = exp_q.pop_front();
          checks++; if (obs_rdw !== exp_v) begin errors++; $display("FAIL rnd_load it=%0d f3=%0d got=%h exp=%h", it, f3, obs_rdw, exp_v); end
          last_load = exp_v;
        end
      end
    end
  endtask

  task automatic test_timeout();
    int   access_cycles = 0;
    logic seen = 1'b0;
    MemReadM = 1'b1; AddressM = 32'h40; Funct3M = 3'b010;
    @(posedge clk); #1;
`ifdef MEM_TIMEOUT_EN
    for (int c = 0; c < 20 && !seen; c++) begin
      if (AccessFaultM === 1'b1) seen = 1'b1;
      else begin
        if (StallM) access_cycles++;
        @(posedge clk); #1;
      end
    end
    checks++; if (!seen)               begin errors++; $display("FAIL to_fault_seen got=0 exp=1"); end
    checks++; if (access_cycles != 4)  begin errors++; $display("FAIL to_access_cycles got=%0d exp=4", access_cycles); end
    checks++; if (StallM !== 1'b0)     begin errors++; $display("FAIL to_stall got=%b exp=0", StallM); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL to_req got=%b exp=0", bus.mem_req); end
    checks++; if (ReadDataW !== last_load) begin errors++; $display("FAIL to_rdw got=%h exp=%h", ReadDataW, last_load); end
    @(posedge clk); #1;
    idle_inputs();
    checks++; if (AccessFaultM !== 1'b0) begin errors++; $display("FAIL to_pulse_width got=%b exp=0", AccessFaultM); end
`else
    for (int c = 0; c < 20; c++) begin
      if (AccessFaultM !== 1'b0) seen = 1'b1;
      if (StallM === 1'b1 && bus.mem_req === 1'b1) access_cycles++;
      @(posedge clk); #1;
    end
    checks++; if (seen)                 begin errors++; $display("FAIL nto_fault got=1 exp=0"); end
    checks++; if (access_cycles != 20)  begin errors++; $display("FAIL nto_wait_cycles got=%0d exp=20", access_cycles); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    checks++; if (ReadDataW !== 32'h0BAD_F00D) begin errors++; $display("FAIL nto_late_load got=%h exp=0badf00d", ReadDataW); end
    checks++; if (StallM !== 1'b0)      begin errors++; $display("FAIL nto_done_stall got=%b exp=0", StallM); end
    last_load = 32'h0BAD_F00D;
    @(posedge clk); #1;
    idle_inputs();
`endif
  endtask

  task automatic test_reset_in_access();
    MemReadM = 1'b1; AddressM = 32'h80; Funct3M = 3'b010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rst_acc_pre_req got=%b exp=1", bus.mem_req); end
    #2;
    reset = 1'b0; idle_inputs();
    #1;
    checks++; if (bus.mem_req !== 1'b0)  begin errors++; $display("FAIL rst_acc_req got=%b exp=0", bus.mem_req); end
    checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL rst_acc_state got=%0d exp=0", fsm_state); end
    checks++; if (ReadDataW !== 32'd0)   begin errors++; $display("FAIL rst_acc_rdw got=%h exp=0", ReadDataW); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL rst_late_ack_state got=%0d exp=0", fsm_state); end
    checks++; if (ReadDataW !== 32'd0)   begin errors++; $display("FAIL rst_late_ack_rdw got=%h exp=0", ReadDataW); end
    checks++; if (bus.mem_req !== 1'b0 || StallM !== 1'b0)
      begin errors++; $display("FAIL rst_late_ack_req_stall got=%b%b exp=00", bus.mem_req, StallM); end
    last_load = 32'd0;
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_ack_outside();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_in_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, max cycles waiting for mem_ack (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemReadM  in  1  load request from memory stage.
- MemWriteM  in  1  store request from memory stage.
- AddressM  in  32  byte address (ALU result).
- WriteDataM  in  32  store source data.
- Funct3M  in  3  access size/sign.
- StallM  out  1  hold pipeline while access is outstanding.
- MisalignedM  out  1  illegal or misaligned access.
- ReadDataW  out  32  extended load result.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable.
- mem_addr  out  32  word address, bits[1:0]=0.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  memory completion, one-cycle pulse.
- mem_rdata  in  32  read word, valid with mem_ack.
- AccessFaultM  out  1  timeout pulse (MEM_TIMEOUT_EN only; tied 0 otherwise).

Function
REQ-003 SHALL implement FSM IDLE, ACCESS, DONE.
REQ-004 MisalignedM SHALL be combinational: high when a request is present and Funct3M is 011/110/111, halfword has AddressM[0]=1, or word has AddressM[1:0]!=0; no access and no stall then.
REQ-005 IDLE: on a legal request, register mem_req=1, mem_we=MemWriteM, mem_addr, mem_wdata, mem_be; go to ACCESS.
REQ-006 MemReadM and MemWriteM both high SHALL be a store; ReadDataW is unchanged.
REQ-007 StallM SHALL be high combinationally in IDLE with a legal request, and high throughout ACCESS.
REQ-008 ACCESS: mem_req and all mem_* outputs SHALL hold stable until mem_ack; on mem_ack drop mem_req and go to DONE.
REQ-009 On mem_ack of a load, ReadDataW SHALL register the extended lane of mem_rdata: LB/LBU byte AddressM[1:0], LH/LHU half AddressM[1]; sign- or zero-extend per Funct3M.
REQ-010 ReadDataW SHALL hold until the next completed load.
REQ-011 DONE SHALL last exactly one cycle with StallM low and return to IDLE; a request seen in DONE SHALL be ignored, so one instruction causes one access.
REQ-012 Byte enables: SB = 0001<<AddressM[1:0]; SH = 0011<<(2*AddressM[1]); SW = 1111.
REQ-013 Store data: byte replicated in 4 lanes; halfword in 2 lanes; word as-is.
REQ-014 mem_ack outside ACCESS SHALL be ignored.
REQ-015 Minimum latency: request at cycle 0, ack at cycle 1, StallM low at cycle 2 (DONE).

Reset
REQ-016 reset low SHALL immediately force state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, ReadDataW=0, AccessFaultM=0, timeout counter=0.
REQ-017 Reset during ACCESS SHALL abandon the access; an ack after release SHALL be ignored.

Configuration
REQ-018 Macro MEM_TIMEOUT_EN defined: ACCESS counts cycles; after TIMEOUT_CYCLES cycles without mem_ack, drop mem_req, pulse AccessFaultM for one cycle, leave ReadDataW unchanged, go to DONE.
REQ-019 MEM_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; AccessFaultM is constant 0.

Verification
REQ-020 SW to 0x100 with data 0xDEADBEEF, ack after 3 cycles -> mem_be=1111, mem_addr=0x100, StallM high 4 cycles, then low for 1 cycle.
REQ-021 LB at 0x103, mem_rdata=0x80FF_FFFF -> ReadDataW=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-022 SH at 0x202 with data 0x1234 -> mem_be=1100, mem_wdata=0x12341234, mem_addr=0x200.
REQ-023 LW at 0x101 -> MisalignedM=1, StallM=0, mem_req stays 0.
REQ-024 Reset asserted 2 cycles into ACCESS, ack arrives after release -> mem_req=0 at once, FSM stays IDLE, ReadDataW=0.
REQ-025 With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> AccessFaultM pulses after 4 ACCESS cycles, then StallM deasserts.
